alu_issue: RTL

Execute-stage sequencer that sits in front of the combinational `ALU`. It accepts decoded operations over a valid/ready handshake and holds them in an operand register that drives the ALU's `rsa`, `rsb` and `op_code`. It captures `out` and the four flags into a result register, and presents results to register-file writeback over a second valid/ready handshake. It also maintains the architectural status-flag register.

---
 rtl/alu_issue.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// Execute-stage sequencer: E (operand) and W (result) registers around an external combinational ALU,
// plus the architectural status flags. Optional macro ALU_ISSUE_BYPASS_EN forwards W data into E operands.
module alu_issue (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_op,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rsa_idx,
   input  logic [4:0]  in_rsb_idx,
   input  logic [31:0] in_rsa,
   input  logic [31:0] in_rsb,
   input  logic        flush,
   output logic [31:0] alu_rsa,
   output logic [31:0] alu_rsb,
   output logic [3:0]  alu_op_code,
   input  logic [31:0] alu_out,
   input  logic        alu_flag_carry,
   input  logic        alu_flag_overflow,
   input  logic        alu_flag_parity,
   input  logic        alu_flag_neg,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic [3:0]  status,
   output logic        illegal_op,
   output logic        busy
);

   logic        e_v;
   logic [3:0]  e_op;
   logic [4:0]  e_rd;
   logic [31:0] e_rsa;
   logic [31:0] e_rsb;

   logic        w_v;
   logic [4:0]  w_rd;
   logic [31:0] w_data;

   logic [3:0]  status_reg;
   logic        illegal_reg;

   logic        e_legal;
   logic        e_carry_op;
   logic        transfer;
   logic        accept;

   always_comb begin
      e_legal = 1'b0;
      case (e_op)
         4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7,
         4'd8, 4'd9, 4'd10, 4'd11, 4'd12: e_legal = 1'b1;
         default:                         e_legal = 1'b0;
      endcase
   end

   assign e_carry_op = (e_op == 4'd0) || (e_op == 4'd1);

   // W drains on the same edge it is refilled, so a full W with wb_ready high is no stall.
   assign transfer = e_v && (!w_v || wb_ready);
   assign in_ready = !flush && (!e_v || transfer);
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_v   <= 1'b0;
         e_op  <= 4'd0;
         e_rd  <= 5'd0;
         e_rsa <= 32'd0;
         e_rsb <= 32'd0;
      end else if (flush) begin
         e_v <= 1'b0;
      end else if (accept) begin
         e_v   <= 1'b1;
         e_op  <= in_op;
         e_rd  <= in_rd;
         e_rsa <= in_rsa;
         e_rsb <= in_rsb;
      end else if (transfer) begin
         e_v <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_v    <= 1'b0;
         w_rd   <= 5'd0;
         w_data <= 32'd0;
      end else if (flush) begin
         w_v <= 1'b0;
      end else if (transfer) begin
         w_v    <= 1'b1;
         w_rd   <= e_rd;
         w_data <= e_legal ? alu_out : 32'd0;
      end else if (wb_ready) begin
         w_v <= 1'b0;
      end
   end

   // Status and the illegal pulse only ever follow an entry that actually lands in W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status_reg  <= 4'd0;
         illegal_reg <= 1'b0;
      end else if (flush) begin
         illegal_reg <= 1'b0;
      end else begin
         illegal_reg <= transfer && !e_legal;
         if (transfer && e_legal) begin
            status_reg[2] <= alu_flag_overflow;
            status_reg[1] <= alu_flag_parity;
            status_reg[0] <= alu_flag_neg;
            if (e_carry_op) begin
               status_reg[3] <= alu_flag_carry;
            end
         end
      end
   end

`ifdef ALU_ISSUE_BYPASS_EN
   logic [4:0] e_rsa_idx;
   logic [4:0] e_rsb_idx;
   logic       fwd_a;
   logic       fwd_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_rsa_idx <= 5'd0;
         e_rsb_idx <= 5'd0;
      end else if (!flush && accept) begin
         e_rsa_idx <= in_rsa_idx;
         e_rsb_idx <= in_rsb_idx;
      end
   end

   // W cannot change while E stalls, so forwarded operands stay stable through a stall.
   assign fwd_a   = w_v && (w_rd != 5'd0) && (e_rsa_idx == w_rd);
   assign fwd_b   = w_v && (w_rd != 5'd0) && (e_rsb_idx == w_rd);
   assign alu_rsa = fwd_a ? w_data : e_rsa;
   assign alu_rsb = fwd_b ? w_data : e_rsb;
`else
   logic unused_idx;
   assign unused_idx = ^{in_rsa_idx, in_rsb_idx};
   assign alu_rsa    = e_rsa;
   assign alu_rsb    = e_rsb;
`endif

   assign alu_op_code = e_op;
   assign wb_valid    = w_v;
   assign wb_rd       = w_rd;
   assign wb_data     = w_data;
   assign status      = status_reg;
   assign illegal_op  = illegal_reg;
   assign busy        = e_v || w_v;

endmodule
